// File: rtl/ula_sequenciador.sv
// ALU sequencer: accepts one request, decodes ALUOp/funct, drives the ALU,
// waits ALU_LAT edges, then returns result/zero on a valid/ready response.
module ula_sequenciador #(
    parameter int unsigned W       = 32,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic [W-1:0]     alu_entrada1,
    output logic [W-1:0]     alu_entrada2,
    output logic [2:0]       alu_control,
    input  logic [W-1:0]     alu_resultado,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_resultado,
    output logic             rsp_zero,
    output logic             rsp_erro,
    output logic [CNT_W-1:0] ops_count
);

    localparam int unsigned CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]        ctl_q, ctl_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              zero_q, zero_d, erro_q, erro_d;
    logic [CNT_W-1:0]  ops_q, ops_d;
    logic [2:0]        dec_ctl;
    logic              dec_ok;

    always_comb begin
        dec_ctl = '0;
        dec_ok  = 1'b1;
        case (req_aluop)
            2'b00: dec_ctl = 3'b010;
            2'b01: dec_ctl = 3'b011;
            2'b10: begin
                case (req_funct)
                    6'b100000: dec_ctl = 3'b010;
                    6'b100010: dec_ctl = 3'b011;
                    6'b100100: dec_ctl = 3'b000;
                    6'b100101: dec_ctl = 3'b001;
                    6'b101010: dec_ctl = 3'b100;
                    default:   dec_ok  = 1'b0;
                endcase
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctl_d   = ctl_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        erro_d  = erro_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_ok) begin
                        a_d     = req_a;
                        b_d     = req_b;
                        ctl_d   = dec_ctl;
                        cnt_d   = CW'(ALU_LAT);
                        state_d = EXEC;
                    end else begin
                        // ALU inputs deliberately untouched on an illegal request
                        erro_d  = 1'b1;
                        res_d   = '0;
                        zero_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_d   = alu_resultado;
                    zero_d  = alu_zero;
                    erro_d  = 1'b0;
                    ops_d   = ops_q + 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            erro_q  <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            erro_q  <= erro_d;
            ops_q   <= ops_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == DONE);
    assign alu_entrada1  = a_q;
    assign alu_entrada2  = b_q;
    assign alu_control   = ctl_q;
    assign rsp_resultado = res_q;
    assign rsp_zero      = zero_q;
    assign rsp_erro      = erro_q;
    assign ops_count     = ops_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador: a registered-ALU instance (ALU_LAT=1)
// and a small-counter, combinational-ALU instance (ALU_LAT=0) for wrap-around.
module tb_ula_sequenciador;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_aluop = '0;
    logic [5:0]  req_funct = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [31:0] alu_entrada1, alu_entrada2;
    logic [2:0]  alu_control;
    logic [31:0] alu_resultado = '0;
    logic        alu_zero = 1'b0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_resultado;
    logic        rsp_zero, rsp_erro;
    logic [15:0] ops_count;

    logic        w_req_valid = 1'b0, w_req_ready;
    logic [31:0] w_req_a = '0, w_req_b = '0;
    logic [31:0] w_entrada1, w_entrada2, w_resultado;
    logic [2:0]  w_control;
    logic        w_zero, w_rsp_valid, w_rsp_zero, w_rsp_erro;
    logic        w_rsp_ready = 1'b1;
    logic [31:0] w_rsp_resultado;
    logic [3:0]  w_ops_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU: result valid one edge after inputs settle
    always @(posedge clock) begin
        alu_resultado <= alu_f(alu_control, alu_entrada1, alu_entrada2);
        alu_zero      <= (alu_f(alu_control, alu_entrada1, alu_entrada2) == 32'd0);
    end

    assign w_resultado = alu_f(w_control, w_entrada1, w_entrada2);
    assign w_zero      = (w_resultado == 32'd0);

    ula_sequenciador #(.W(32), .ALU_LAT(1), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_entrada1(alu_entrada1), .alu_entrada2(alu_entrada2), .alu_control(alu_control),
        .alu_resultado(alu_resultado), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resultado(rsp_resultado), .rsp_zero(rsp_zero), .rsp_erro(rsp_erro),
        .ops_count(ops_count)
    );

    ula_sequenciador #(.W(32), .ALU_LAT(0), .CNT_W(4)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_aluop(2'b00), .req_funct(6'b000000), .req_a(w_req_a), .req_b(w_req_b),
        .alu_entrada1(w_entrada1), .alu_entrada2(w_entrada2), .alu_control(w_control),
        .alu_resultado(w_resultado), .alu_zero(w_zero),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
        .rsp_resultado(w_rsp_resultado), .rsp_zero(w_rsp_zero), .rsp_erro(w_rsp_erro),
        .ops_count(w_ops_count)
    );

    // Presents a request and returns #1 after the edge on which it was accepted.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clock);
        req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen; -1 on timeout.
    task automatic wait_rsp(output int edges);
        edges = 0;
        do begin
            @(posedge clock); #1;
            edges++;
        end while (!rsp_valid && edges < 20);
        if (!rsp_valid) edges = -1;
    endtask

    task automatic ack;
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (ops_count !== 16'd0) begin n_err++; $display("FAIL reset_ops_count: got %h expected 0", ops_count); end
        n_cmp++; if (alu_control !== 3'b000) begin n_err++; $display("FAIL reset_alu_control: got %b expected 000", alu_control); end
        n_cmp++; if (rsp_resultado !== 32'd0) begin n_err++; $display("FAIL reset_rsp_resultado: got %h expected 0", rsp_resultado); end
        n_cmp++; if (alu_entrada1 !== 32'd0) begin n_err++; $display("FAIL reset_alu_entrada1: got %h expected 0", alu_entrada1); end
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_erro !== 1'b0) begin n_err++; $display("FAIL reset_rsp_erro: got %b expected 0", rsp_erro); end
    endtask

    task automatic test_radd;
        int e;
        issue(2'b10, 6'b100000, 32'd5, 32'd7);
        n_cmp++; if (alu_control !== 3'b010) begin n_err++; $display("FAIL radd_control: got %b expected 010", alu_control); end
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL radd_req_ready: got %b expected 0", req_ready); end
        wait_rsp(e);
        n_cmp++; if (e !== 2) begin n_err++; $display("FAIL radd_latency: got %0d expected 2", e); end
        n_cmp++; if (rsp_resultado !== 32'd12) begin n_err++; $display("FAIL radd_result: got %h expected c", rsp_resultado); end
        n_cmp++; if (rsp_zero !== 1'b0) begin n_err++; $display("FAIL radd_zero: got %b expected 0", rsp_zero); end
        n_cmp++; if (ops_count !== 16'd1) begin n_err++; $display("FAIL radd_ops: got %0d expected 1", ops_count); end
        ack();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL radd_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_beq;
        int e;
        issue(2'b01, 6'b000000, 32'h1234, 32'h1234);
        n_cmp++; if (alu_control !== 3'b011) begin n_err++; $display("FAIL beq_control: got %b expected 011", alu_control); end
        wait_rsp(e);
        n_cmp++; if (rsp_resultado !== 32'd0) begin n_err++; $display("FAIL beq_result: got %h expected 0", rsp_resultado); end
        n_cmp++; if (rsp_zero !== 1'b1) begin n_err++; $display("FAIL beq_zero: got %b expected 1", rsp_zero); end
        n_cmp++; if (rsp_erro !== 1'b0) begin n_err++; $display("FAIL beq_erro: got %b expected 0", rsp_erro); end
        n_cmp++; if (ops_count !== 16'd2) begin n_err++; $display("FAIL beq_ops: got %0d expected 2", ops_count); end
        ack();
    endtask

    task automatic test_slt_stall;
        int e;
        issue(2'b10, 6'b101010, 32'd3, 32'd9);
        n_cmp++; if (alu_control !== 3'b100) begin n_err++; $display("FAIL slt_control: got %b expected 100", alu_control); end
        wait_rsp(e);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL slt_stall_valid[%0d]: got %b expected 1", i, rsp_valid); end
            n_cmp++; if (rsp_resultado !== 32'd1) begin n_err++; $display("FAIL slt_stall_result[%0d]: got %h expected 1", i, rsp_resultado); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL slt_stall_ready[%0d]: got %b expected 0", i, req_ready); end
        end
        ack();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL slt_idle_after_ack: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_resultado !== 32'd1) begin n_err++; $display("FAIL slt_hold_after_ack: got %h expected 1", rsp_resultado); end
        n_cmp++; if (ops_count !== 16'd3) begin n_err++; $display("FAIL slt_ops: got %0d expected 3", ops_count); end
    endtask

    task automatic test_illegal;
        int e;
        issue(2'b10, 6'b000111, 32'hAA, 32'hBB);
        wait_rsp(e);
        n_cmp++; if (e !== 1) begin n_err++; $display("FAIL illegal_latency: got %0d expected 1", e); end
        n_cmp++; if (rsp_erro !== 1'b1) begin n_err++; $display("FAIL illegal_erro: got %b expected 1", rsp_erro); end
        n_cmp++; if (rsp_resultado !== 32'd0) begin n_err++; $display("FAIL illegal_result: got %h expected 0", rsp_resultado); end
        n_cmp++; if (alu_entrada1 !== 32'd3) begin n_err++; $display("FAIL illegal_entrada1: got %h expected 3", alu_entrada1); end
        n_cmp++; if (alu_entrada2 !== 32'd9) begin n_err++; $display("FAIL illegal_entrada2: got %h expected 9", alu_entrada2); end
        n_cmp++; if (alu_control !== 3'b100) begin n_err++; $display("FAIL illegal_control: got %b expected 100", alu_control); end
        n_cmp++; if (ops_count !== 16'd3) begin n_err++; $display("FAIL illegal_ops: got %0d expected 3", ops_count); end
        ack();
        issue(2'b11, 6'b100000, 32'h1, 32'h2);
        wait_rsp(e);
        n_cmp++; if (e !== 1 || rsp_erro !== 1'b1) begin n_err++; $display("FAIL aluop11: got lat=%0d erro=%b expected lat=1 erro=1", e, rsp_erro); end
        ack();
    endtask

    task automatic test_back_to_back;
        int e;
        issue(2'b10, 6'b100100, 32'hF0F0, 32'hFF00);
        wait_rsp(e);
        n_cmp++; if (rsp_resultado !== 32'hF000 || rsp_erro !== 1'b0) begin n_err++; $display("FAIL and_result: got %h erro=%b expected f000 erro=0", rsp_resultado, rsp_erro); end
        ack();
        issue(2'b10, 6'b100101, 32'hF0F0, 32'hFF00);
        wait_rsp(e);
        n_cmp++; if (rsp_resultado !== 32'hFFF0) begin n_err++; $display("FAIL or_result: got %h expected fff0", rsp_resultado); end
        ack();
        issue(2'b10, 6'b100010, 32'd3, 32'd10);
        wait_rsp(e);
        n_cmp++; if (rsp_resultado !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL sub_result: got %h expected fffffff9", rsp_resultado); end
        ack();
        issue(2'b00, 6'b111111, 32'h10, 32'h20);
        wait_rsp(e);
        n_cmp++; if (rsp_resultado !== 32'h30) begin n_err++; $display("FAIL lw_add_result: got %h expected 30", rsp_resultado); end
        n_cmp++; if (ops_count !== 16'd7) begin n_err++; $display("FAIL b2b_ops: got %0d expected 7", ops_count); end
        ack();
    endtask

    task automatic test_reset_midexec;
        issue(2'b00, 6'b000000, 32'd1, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL midexec_ready: got %b expected 1", req_ready); end
        n_cmp++; if (ops_count !== 16'd0) begin n_err++; $display("FAIL midexec_ops: got %0d expected 0", ops_count); end
        n_cmp++; if (alu_control !== 3'b000) begin n_err++; $display("FAIL midexec_control: got %b expected 000", alu_control); end
        @(negedge clock) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midexec_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
        end
    endtask

    task automatic test_wrap;
        int n;
        logic [3:0] exp_ops;
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            w_req_a = i; w_req_b = 32'd1; w_req_valid = 1'b1;
            n = 0;
            while (!w_req_ready && n < 20) begin @(negedge clock); n++; end
            @(posedge clock); #1;
            w_req_valid = 1'b0;
            n = 0;
            do begin @(posedge clock); #1; n++; end while (!w_rsp_valid && n < 20);
            exp_ops = 4'(i + 1);
            n_cmp++; if (n !== 1) begin n_err++; $display("FAIL wrap_latency[%0d]: got %0d expected 1", i, n); end
            n_cmp++; if (w_rsp_resultado !== 32'(i + 1)) begin n_err++; $display("FAIL wrap_result[%0d]: got %h expected %h", i, w_rsp_resultado, i + 1); end
            n_cmp++; if (w_ops_count !== exp_ops) begin n_err++; $display("FAIL wrap_ops[%0d]: got %h expected %h", i, w_ops_count, exp_ops); end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_radd();
        test_beq();
        test_slt_stall();
        test_illegal();
        test_back_to_back();
        test_reset_midexec();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
